// File: rtl/bus_select_encoder_pkg.sv
// bus_enc_pkg: shared constants for the bus-select encoder.
//   MODE_FIXED / MODE_RR select the arbitration mode.
//   CNT_W_DEF is the default width of the error counter.
package bus_enc_pkg;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int CNT_W_DEF  = 8;
endpackage

// File: rtl/bus_select_encoder_if.sv
// bus_select_encoder_if: request/select bundle between control unit and encoder.
//   en, hold, req, err_clr               : requester -> encoder
//   code, code_valid, none, multi, err_count : encoder -> bus mux / debug
interface bus_select_encoder_if #(
    parameter int N     = 32,
    parameter int W     = $clog2(N),
    parameter int CNT_W = 8
) ();
    logic             en;
    logic             hold;
    logic [N-1:0]     req;
    logic             err_clr;
    logic [W-1:0]     code;
    logic             code_valid;
    logic             none;
    logic             multi;
    logic [CNT_W-1:0] err_count;

    modport master (
        output en, hold, req, err_clr,
        input  code, code_valid, none, multi, err_count
    );

    modport slave (
        input  en, hold, req, err_clr,
        output code, code_valid, none, multi, err_count
    );
endinterface

// File: rtl/bus_select_encoder_rr_pick.sv
// rr_pick: first set bit of req at or above start, wrapping from N-1 to 0.
//   req   : request vector
//   start : search origin
//   idx   : winning index (0 when req is empty)
//   any   : req has at least one bit set
module rr_pick #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         any
);
    int   j;
    logic found;

    assign any = |req;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(start) + k;
            j = (j >= N) ? j - N : j;
            if (!found && req[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_select_encoder.sv
// bus_select_encoder: registered one-hot/multi-hot request to bus-mux select code.
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : slave side of bus_select_encoder_if (en/hold/req/err_clr in,
//           code/code_valid/none/multi/err_count out, all registered)
module bus_select_encoder
    import bus_enc_pkg::*;
#(
    parameter int N     = 32,
    parameter int W     = $clog2(N),
    parameter int MODE  = MODE_FIXED,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clock,
    input  logic                  clear,
    bus_select_encoder_if.slave   bus
);
    logic [W-1:0]     code_q, code_d, ptr_q, ptr_d, start, idx, idx_nxt;
    logic             valid_q, valid_d, none_q, none_d, multi_q, multi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             any, multi_hot;

    // Fixed priority is round-robin search anchored at 0.
    assign start = (MODE == MODE_RR) ? ptr_q : '0;

    rr_pick #(.N(N), .W(W)) u_pick (
        .req   (bus.req),
        .start (start),
        .idx   (idx),
        .any   (any)
    );

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_hot = |(bus.req & (bus.req - 1'b1));
    assign idx_nxt   = (idx == W'(N - 1)) ? '0 : idx + 1'b1;

    always_comb begin
        code_d  = code_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        none_d  = none_q;
        multi_d = multi_q;
        cnt_d   = cnt_q;
        if (!bus.hold) begin
            valid_d = bus.en && any;
            none_d  = bus.en && !any;
            multi_d = bus.en && multi_hot;
            if (bus.en && any) begin
                code_d = idx;
                ptr_d  = (MODE == MODE_RR) ? idx_nxt : '0;
            end
            if (bus.en && multi_hot && cnt_q != '1)
                cnt_d = cnt_q + 1'b1;
        end
        if (bus.err_clr)
            cnt_d = '0;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            code_q  <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            none_q  <= 1'b0;
            multi_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            code_q  <= code_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            none_q  <= none_d;
            multi_q <= multi_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.code       = code_q;
    assign bus.code_valid = valid_q;
    assign bus.none       = none_q;
    assign bus.multi      = multi_q;
    assign bus.err_count  = cnt_q;
endmodule

// File: tb/tb_bus_select_encoder.sv
// tb_bus_select_encoder: scoreboard bench driving a fixed-priority and a round-robin encoder in parallel.
module tb_bus_select_encoder;
    import bus_enc_pkg::*;

    typedef struct {
        int c0;
        int c1;
        int v;
        int n;
        int m;
        int cnt;
    } exp_t;

    logic        clock;
    logic        clear;
    logic        en, hold, err_clr;
    logic [31:0] req;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    int mcode0, mcode1, mvalid, mnone, mmulti, mcnt, mptr;

    bus_select_encoder_if #(.N(32), .W(5), .CNT_W(8)) b0 ();
    bus_select_encoder_if #(.N(32), .W(5), .CNT_W(8)) b1 ();

    assign b0.en = en;  assign b0.hold = hold;  assign b0.req = req;  assign b0.err_clr = err_clr;
    assign b1.en = en;  assign b1.hold = hold;  assign b1.req = req;  assign b1.err_clr = err_clr;

    bus_select_encoder #(.N(32), .MODE(MODE_FIXED), .CNT_W(8)) u_fix (
        .clock (clock),
        .clear (clear),
        .bus   (b0)
    );

    bus_select_encoder #(.N(32), .MODE(MODE_RR), .CNT_W(8)) u_rr (
        .clock (clock),
        .clear (clear),
        .bus   (b1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        mcode0 = 0; mcode1 = 0; mvalid = 0; mnone = 0; mmulti = 0; mcnt = 0; mptr = 0;
    endtask

    // One sample: apply inputs, advance the reference model, queue its expectation, clock.
    task automatic cycle(input logic e_i, input logic h_i, input logic [31:0] r_i, input logic ec_i);
        int nb;
        int j;
        bit found;
        en = e_i; hold = h_i; req = r_i; err_clr = ec_i;
        if (!h_i) begin
            nb     = $countones(r_i);
            mvalid = (e_i && nb > 0) ? 1 : 0;
            mnone  = (e_i && nb == 0) ? 1 : 0;
            mmulti = (e_i && nb > 1) ? 1 : 0;
            if (e_i && nb > 0) begin
                found = 0;
                for (int i = 0; i < 32; i++)
                    if (!found && r_i[i]) begin mcode0 = i; found = 1; end
                found = 0;
                for (int k = 0; k < 32; k++) begin
                    j = (mptr + k) % 32;
                    if (!found && r_i[j]) begin mcode1 = j; found = 1; end
                end
                mptr = (mcode1 + 1) % 32;
            end
            if (e_i && nb > 1 && mcnt < 255) mcnt++;
        end
        if (ec_i) mcnt = 0;
        q.push_back('{c0: mcode0, c1: mcode1, v: mvalid, n: mnone, m: mmulti, cnt: mcnt});
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("fix.code",       int'(b0.code),       e.c0);
            chk("rr.code",        int'(b1.code),       e.c1);
            chk("fix.code_valid", int'(b0.code_valid), e.v);
            chk("rr.code_valid",  int'(b1.code_valid), e.v);
            chk("fix.none",       int'(b0.none),       e.n);
            chk("rr.none",        int'(b1.none),       e.n);
            chk("fix.multi",      int'(b0.multi),      e.m);
            chk("rr.multi",       int'(b1.multi),      e.m);
            chk("fix.err_count",  int'(b0.err_count),  e.cnt);
            chk("rr.err_count",   int'(b1.err_count),  e.cnt);
        end
    end

    task automatic chk_zero(input string tag);
        chk({tag, ".fix.code"},  int'(b0.code),       0);
        chk({tag, ".rr.code"},   int'(b1.code),       0);
        chk({tag, ".fix.valid"}, int'(b0.code_valid), 0);
        chk({tag, ".rr.valid"},  int'(b1.code_valid), 0);
        chk({tag, ".fix.none"},  int'(b0.none),       0);
        chk({tag, ".rr.none"},   int'(b1.none),       0);
        chk({tag, ".fix.multi"}, int'(b0.multi),      0);
        chk({tag, ".rr.multi"},  int'(b1.multi),      0);
        chk({tag, ".fix.cnt"},   int'(b0.err_count),  0);
        chk({tag, ".rr.cnt"},    int'(b1.err_count),  0);
    endtask

    initial begin
        logic [31:0] r;
        int sel;
        clear = 1'b0; en = 1'b0; hold = 1'b0; req = '0; err_clr = 1'b0;
        model_reset();
        #3;
        chk_zero("reset");
        @(posedge clock);
        #2;
        clear = 1'b1;

        for (int i = 0; i < 32; i++) cycle(1, 0, 32'd1 << i, 0);

        for (int i = 0; i < 300; i++) cycle(1, 0, 32'h8000_0014, 0);

        cycle(1, 0, 32'h8000_0014, 1);
        cycle(1, 0, 32'h0000_0080, 0);
        cycle(1, 0, 32'h0000_0000, 0);
        cycle(0, 0, 32'h0000_0000, 0);

        cycle(1, 0, 32'h0000_0300, 0);
        for (int i = 0; i < 5; i++) cycle(1'($urandom_range(0, 1)), 1, $urandom, 0);
        cycle(0, 1, 32'h0000_0006, 1);
        cycle(1, 0, 32'h0000_0006, 1);

        for (int i = 0; i < 3; i++) cycle(1, 0, 32'h0000_0011, 0);
        cycle(1, 0, 32'd1 << 19, 0);
        clear = 1'b0;
        model_reset();
        #1;
        chk_zero("async_reset");
        clear = 1'b1;
        cycle(1, 0, 32'h8000_0014, 0);
        cycle(1, 0, 32'h8000_0014, 0);

        for (int i = 0; i < 500; i++) begin
            sel = $urandom_range(0, 3);
            r = (sel == 0) ? 32'h0 :
                (sel == 1) ? (32'd1 << $urandom_range(0, 31)) :
                (sel == 2) ? ((32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31))) :
                $urandom;
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), r,
                  1'($urandom_range(0, 15) == 0));
        end

        en = 1'b0; hold = 1'b0; err_clr = 1'b0;
        repeat (2) @(posedge clock);
        #2;
        chk("scoreboard_drain", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
